adder_accumulator: RTL

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

---
 rtl/acc_pkg.sv | 13 +
 rtl/acc_add_core.sv | 17 +
 rtl/adder_accumulator.sv | 104 ++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types and default widths for the adder/accumulator.
package acc_pkg;

  localparam int N_DEF  = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/acc_add_core.sv
// N-bit adder with carry-in and carry-out.
module acc_add_core
  import acc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b}
                     + {{N{1'b0}}, cin};

endmodule

// File: rtl/adder_accumulator.sv
// Grouped accumulator: sums beats until in_last, counts carries.
// Define ACC_SATURATE_EN for a sticky all-ones saturating sum.
module adder_accumulator
  import acc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic [CW-1:0] out_carry_cnt,
  output logic          out_ovf
);

  localparam logic [CW-1:0] CMAX = '1;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_nxt;
  logic [N-1:0]  sum;
  logic [CW-1:0] cnt;
  logic          c;
  logic          in_fire;
  logic          out_fire;

  acc_add_core #(.N(N)) u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef ACC_SATURATE_EN
  // Once pinned at all-ones the sum stays there for the group.
  assign acc_nxt = (c | (&acc)) ? '1 : sum;
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            acc <= in_data;
            cnt <= '0;
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(c & (cnt != CMAX));
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum       = acc;
  assign out_carry_cnt = cnt;
  assign out_ovf       = (cnt == CMAX);

endmodule
